// File: rtl/comm_pkg.sv
// Shared types and command table for the UART command-frame controller.
// The decode table maps a command byte to the number of operand bytes that follow it.
package comm_pkg;

    typedef enum logic [2:0] {
        DISCONNECT = 3'd0,
        IDLE       = 3'd1,
        GET_OPDS   = 3'd2,
        MEM        = 3'd3,
        RESP       = 3'd4
    } state_t;

    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NACK_BYTE = 8'h15;
    localparam logic [7:0] CMD_PING  = 8'h03;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int CMD_TBL_N = 3;
    localparam logic [7:0] CMD_CODE  [CMD_TBL_N] = '{CMD_PING, CMD_READ, CMD_WRITE};
    localparam int         CMD_NOPDS [CMD_TBL_N] = '{0, 2, 3};

endpackage

// File: rtl/comm_cmd_decode.sv
// Combinational command decoder: byte -> {valid, operand count}.
// Entries needing more operands than there are register slots decode as invalid.
module comm_cmd_decode
    import comm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_OPDS = 4,
    parameter int NOPDS_W  = $clog2(MAX_OPDS + 1)
) (
    input  logic [DATA_W-1:0]  cmd_byte,
    output logic               valid,
    output logic [NOPDS_W-1:0] nopds
);

    logic [CMD_TBL_N-1:0] hit;

    generate
        for (genvar gi = 0; gi < CMD_TBL_N; gi++) begin : g_tbl
            assign hit[gi] = (cmd_byte == DATA_W'(CMD_CODE[gi])) && (CMD_NOPDS[gi] <= MAX_OPDS);
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        nopds = '0;
        for (int i = 0; i < CMD_TBL_N; i++) begin
            if (hit[i]) begin
                valid = 1'b1;
                nopds = NOPDS_W'(CMD_NOPDS[i]);
            end
        end
    end

endmodule

// File: rtl/comm_frame_ctrl.sv
// Command-frame controller: frames cmd + operands from the rx byte stream, requests memory,
// and answers with ACK/NACK. One shared down-counter times the idle, operand and memory phases.
module comm_frame_ctrl
    import comm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_OPDS = 4,
    parameter int IDLE_TO  = 1000,
    parameter int OPDS_TO  = 200,
    parameter int MEM_TO   = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           connect,
    input  logic                           disconnect,
    input  logic                           rx_valid,
    input  logic [DATA_W-1:0]              rx_data,
    output logic                           mem_req,
    input  logic                           mem_gnt,
    output logic [DATA_W-1:0]              cmd_o,
    output logic [MAX_OPDS*DATA_W-1:0]     opds_o,
    output logic [$clog2(MAX_OPDS+1)-1:0]  nopds_o,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [DATA_W-1:0]              tx_data,
    output logic                           timeout_o,
    output logic                           rx_drop_o,
    output logic [2:0]                     state_o
);

    localparam int NOPDS_W = $clog2(MAX_OPDS + 1);
    localparam int TMR_MAX = (IDLE_TO > OPDS_TO) ? ((IDLE_TO > MEM_TO) ? IDLE_TO : MEM_TO)
                                                 : ((OPDS_TO > MEM_TO) ? OPDS_TO : MEM_TO);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] IDLE_LD = TMR_W'(IDLE_TO - 1);
    localparam logic [TMR_W-1:0] OPDS_LD = TMR_W'(OPDS_TO - 1);
    localparam logic [TMR_W-1:0] MEM_LD  = TMR_W'(MEM_TO - 1);

    state_t              state_reg;
    logic [TMR_W-1:0]    tmr_reg;
    logic [NOPDS_W-1:0]  cnt_reg;
    logic [NOPDS_W-1:0]  nopds_reg;
    logic [DATA_W-1:0]   cmd_reg;
    logic [DATA_W-1:0]   opd_reg [MAX_OPDS];
    logic                mem_req_reg, tx_valid_reg, timeout_reg, rx_drop_reg;
    logic [DATA_W-1:0]   tx_data_reg;

    logic                dec_valid;
    logic [NOPDS_W-1:0]  dec_nopds;
    logic                tmr_expired;

    comm_cmd_decode #(
        .DATA_W   (DATA_W),
        .MAX_OPDS (MAX_OPDS),
        .NOPDS_W  (NOPDS_W)
    ) u_dec (
        .cmd_byte (rx_data),
        .valid    (dec_valid),
        .nopds    (dec_nopds)
    );

    assign tmr_expired = (tmr_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= DISCONNECT;
            tmr_reg      <= '0;
            cnt_reg      <= '0;
            nopds_reg    <= '0;
            cmd_reg      <= '0;
            mem_req_reg  <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            timeout_reg  <= 1'b0;
            rx_drop_reg  <= 1'b0;
            for (int i = 0; i < MAX_OPDS; i++) opd_reg[i] <= '0;
        end else begin
            timeout_reg <= 1'b0;
            rx_drop_reg <= rx_valid && (state_reg == DISCONNECT || state_reg == MEM || state_reg == RESP);
            // Free-running decrement; state entries below override it with a fresh load.
            if (!tmr_expired) tmr_reg <= tmr_reg - TMR_W'(1);

            if (disconnect && state_reg != DISCONNECT) begin
                state_reg    <= DISCONNECT;
                mem_req_reg  <= 1'b0;
                tx_valid_reg <= 1'b0;
                tx_data_reg  <= '0;
            end else begin
                case (state_reg)
                    DISCONNECT: begin
                        if (connect) begin
                            state_reg <= IDLE;
                            tmr_reg   <= IDLE_LD;
                        end
                    end
                    IDLE: begin
                        if (rx_valid) begin
                            cmd_reg   <= rx_data;
                            nopds_reg <= dec_nopds;
                            for (int i = 0; i < MAX_OPDS; i++) opd_reg[i] <= '0;
                            if (!dec_valid) begin
                                state_reg    <= RESP;
                                tx_valid_reg <= 1'b1;
                                tx_data_reg  <= DATA_W'(NACK_BYTE);
                            end else if (dec_nopds == '0) begin
                                state_reg   <= MEM;
                                mem_req_reg <= 1'b1;
                                tmr_reg     <= MEM_LD;
                            end else begin
                                state_reg <= GET_OPDS;
                                cnt_reg   <= '0;
                                tmr_reg   <= OPDS_LD;
                            end
                        end else if (tmr_expired) begin
                            state_reg   <= DISCONNECT;
                            timeout_reg <= 1'b1;
                        end
                    end
                    GET_OPDS: begin
                        if (rx_valid) begin
                            for (int i = 0; i < MAX_OPDS; i++)
                                if (cnt_reg == NOPDS_W'(i)) opd_reg[i] <= rx_data;
                            cnt_reg <= cnt_reg + NOPDS_W'(1);
                            tmr_reg <= OPDS_LD;
                            if (cnt_reg + NOPDS_W'(1) == nopds_reg) begin
                                state_reg   <= MEM;
                                mem_req_reg <= 1'b1;
                                tmr_reg     <= MEM_LD;
                            end
                        end else if (tmr_expired) begin
                            state_reg    <= RESP;
                            tx_valid_reg <= 1'b1;
                            tx_data_reg  <= DATA_W'(NACK_BYTE);
                            timeout_reg  <= 1'b1;
                        end
                    end
                    MEM: begin
                        if (mem_gnt || tmr_expired) begin
                            state_reg    <= RESP;
                            mem_req_reg  <= 1'b0;
                            tx_valid_reg <= 1'b1;
                            tx_data_reg  <= mem_gnt ? DATA_W'(ACK_BYTE) : DATA_W'(NACK_BYTE);
                            timeout_reg  <= !mem_gnt;
                        end
                    end
                    RESP: begin
                        if (tx_ready) begin
                            state_reg    <= IDLE;
                            tx_valid_reg <= 1'b0;
                            tx_data_reg  <= '0;
                            tmr_reg      <= IDLE_LD;
                        end
                    end
                    default: state_reg <= DISCONNECT;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_OPDS; gi++) begin : g_opds
            assign opds_o[gi*DATA_W +: DATA_W] = opd_reg[gi];
        end
    endgenerate

    assign mem_req   = mem_req_reg;
    assign cmd_o     = cmd_reg;
    assign nopds_o   = nopds_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_data   = tx_data_reg;
    assign timeout_o = timeout_reg;
    assign rx_drop_o = rx_drop_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_comm_frame_ctrl.sv
// Directed plus randomized bench for comm_frame_ctrl, checked against a transaction-level
// model of the command table, operand placement, timeouts and response bytes.
module tb_comm_frame_ctrl;

    localparam int DATA_W   = 8;
    localparam int MAX_OPDS = 4;
    localparam int IDLE_TO  = 50;
    localparam int OPDS_TO  = 20;
    localparam int MEM_TO   = 10;

    localparam logic [2:0] S_DISC = 3'd0, S_IDLE = 3'd1, S_OPDS = 3'd2, S_MEM = 3'd3, S_RESP = 3'd4;

    logic                       clk = 1'b0;
    logic                       rst_n, connect, disconnect, rx_valid, mem_gnt, tx_ready;
    logic [DATA_W-1:0]          rx_data;
    logic                       mem_req, tx_valid, timeout_o, rx_drop_o;
    logic [DATA_W-1:0]          cmd_o, tx_data;
    logic [MAX_OPDS*DATA_W-1:0] opds_o;
    logic [2:0]                 nopds_o;
    logic [2:0]                 state_o;

    int errors = 0;
    int checks = 0;

    comm_frame_ctrl #(
        .DATA_W(DATA_W), .MAX_OPDS(MAX_OPDS),
        .IDLE_TO(IDLE_TO), .OPDS_TO(OPDS_TO), .MEM_TO(MEM_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .connect(connect), .disconnect(disconnect),
        .rx_valid(rx_valid), .rx_data(rx_data), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .cmd_o(cmd_o), .opds_o(opds_o), .nopds_o(nopds_o), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .timeout_o(timeout_o),
        .rx_drop_o(rx_drop_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Reference command table: operand count, or -1 for an unknown command.
    function automatic int ref_nopds(input logic [7:0] b);
        case (b)
            8'h01:   return 2;
            8'h02:   return 3;
            8'h03:   return 0;
            default: return -1;
        endcase
    endfunction

    initial begin
        logic [7:0]  cmd, b, exp_rsp;
        logic [31:0] exp_opds;
        int          n, d, r;

        rst_n = 1'b0; connect = 0; disconnect = 0; rx_valid = 0; rx_data = '0;
        mem_gnt = 0; tx_ready = 0;
        tick(); tick();
        chk("reset_state", state_o, S_DISC);
        chk("reset_outs", {mem_req, tx_valid, timeout_o, rx_drop_o, tx_data}, '0);
        chk("reset_regs", {cmd_o, opds_o, nopds_o}, '0);
        rst_n = 1'b1;
        tick();

        connect = 1; tick(); connect = 0;
        chk("connect_idle", state_o, S_IDLE);

        // WRITE with three operands
        send_byte(8'h02);
        chk("wr_state", state_o, S_OPDS);
        chk("wr_nopds", nopds_o, 3);
        send_byte(8'hA0);
        send_byte(8'h11);
        chk("wr_noreq_early", mem_req, 1'b0);
        send_byte(8'h22);
        chk("wr_mem_req", mem_req, 1'b1);
        chk("wr_opds", opds_o[23:0], 24'h2211A0);
        tick(); tick();
        chk("wr_req_hold", mem_req, 1'b1);
        mem_gnt = 1; tick(); mem_gnt = 0;
        chk("wr_tx_valid", tx_valid, 1'b1);
        chk("wr_tx_ack", tx_data, 8'h06);
        chk("wr_req_drop", mem_req, 1'b0);
        tx_ready = 1; tick(); tx_ready = 0;
        chk("wr_back_idle", state_o, S_IDLE);

        // PING, no operands
        send_byte(8'h03);
        chk("ping_req", mem_req, 1'b1);
        chk("ping_nopds", nopds_o, 0);
        mem_gnt = 1; tick(); mem_gnt = 0;
        chk("ping_ack", tx_data, 8'h06);
        tx_ready = 1; tick(); tx_ready = 0;
        chk("ping_idle", state_o, S_IDLE);

        // Unknown command -> NACK, response held while tx_ready is low
        send_byte(8'hFF);
        chk("bad_nack", {tx_valid, tx_data}, {1'b1, 8'h15});
        chk("bad_noreq", mem_req, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                send_byte(8'hAA);
                chk("resp_rx_drop", rx_drop_o, 1'b1);
            end else begin
                tick();
            end
            chk("resp_stable", {tx_valid, tx_data, state_o}, {1'b1, 8'h15, S_RESP});
        end
        tx_ready = 1; tick(); tx_ready = 0;
        chk("bad_idle", {state_o, tx_valid}, {S_IDLE, 1'b0});

        // Randomized transactions against the model
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: cmd = 8'h01;
                1: cmd = 8'h02;
                2: cmd = 8'h03;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            n = ref_nopds(cmd);
            repeat ($urandom_range(0, 3)) tick();
            send_byte(cmd);
            chk("rnd_cmd", cmd_o, cmd);
            if (n < 0) begin
                exp_rsp = 8'h15;
                chk("rnd_bad_state", state_o, S_RESP);
                chk("rnd_bad_noreq", mem_req, 1'b0);
            end else begin
                exp_opds = '0;
                for (int k = 0; k < n; k++) begin
                    repeat ($urandom_range(0, OPDS_TO - 2)) tick();
                    b = 8'($urandom_range(0, 255));
                    exp_opds[k*8 +: 8] = b;
                    send_byte(b);
                    if (k < n - 1) chk("rnd_noreq_mid", mem_req, 1'b0);
                end
                chk("rnd_req", mem_req, 1'b1);
                chk("rnd_opds", opds_o, exp_opds);
                chk("rnd_nopds", nopds_o, 3'(n));
                d = $urandom_range(0, MEM_TO + 2);
                if (d >= MEM_TO) begin
                    exp_rsp = 8'h15;
                    repeat (MEM_TO - 1) tick();
                    chk("rnd_req_before_to", mem_req, 1'b1);
                    tick();
                    chk("rnd_mem_timeout", timeout_o, 1'b1);
                end else begin
                    exp_rsp = 8'h06;
                    repeat (d) tick();
                    mem_gnt = 1; tick(); mem_gnt = 0;
                    chk("rnd_no_timeout", timeout_o, 1'b0);
                end
            end
            chk("rnd_tx", {tx_valid, tx_data}, {1'b1, exp_rsp});
            r = $urandom_range(0, 3);
            repeat (r) tick();
            chk("rnd_tx_hold", tx_valid, 1'b1);
            tx_ready = 1; tick(); tx_ready = 0;
            chk("rnd_idle", {state_o, tx_valid}, {S_IDLE, 1'b0});
        end

        // Operand timeout, then idle timeout
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (OPDS_TO - 1) tick();
        chk("opd_pre_to", {state_o, timeout_o}, {S_OPDS, 1'b0});
        tick();
        chk("opd_timeout", timeout_o, 1'b1);
        chk("opd_to_nack", {state_o, tx_valid, tx_data}, {S_RESP, 1'b1, 8'h15});
        chk("opd_partial", opds_o, 32'h0000_0010);
        tick();
        chk("opd_to_pulse", timeout_o, 1'b0);
        tx_ready = 1; tick(); tx_ready = 0;
        repeat (IDLE_TO - 1) tick();
        chk("idle_pre_to", state_o, S_IDLE);
        tick();
        chk("idle_timeout", {state_o, timeout_o}, {S_DISC, 1'b1});

        // Disconnect aborts a pending memory request; bytes in DISCONNECT are dropped
        connect = 1; tick(); connect = 0;
        send_byte(8'h03);
        chk("disc_req_up", mem_req, 1'b1);
        disconnect = 1; tick(); disconnect = 0;
        chk("disc_abort", {state_o, mem_req}, {S_DISC, 1'b0});
        send_byte(8'h55);
        chk("disc_rx_drop", {rx_drop_o, state_o}, {1'b1, S_DISC});
        tick();
        chk("disc_drop_pulse", rx_drop_o, 1'b0);

        // Asynchronous reset in the middle of operand collection
        connect = 1; tick(); connect = 0;
        send_byte(8'h02);
        send_byte(8'hA0);
        chk("ar_pre", state_o, S_OPDS);
        rst_n = 1'b0;
        #1;
        chk("ar_state", state_o, S_DISC);
        chk("ar_outs", {mem_req, tx_valid, timeout_o, rx_drop_o, tx_data, cmd_o, opds_o, nopds_o}, '0);
        tick();
        rst_n = 1'b1;
        connect = 1; tick(); connect = 0;
        chk("ar_reconnect", state_o, S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
